regfile_scoreboard: RTL and testbench

- Parametrised register file for the pipelined CPU, with a per-register pending-write scoreboard and an N-source forwarding/bypass network.
- Sits at ID: supplies rs/rt operands and raises the load-use/in-flight interlock stall.
- Generalises the fixed 4x16 file and its 2-source forwarding:
  - configurable width, register count and forwarding depth;
  - synchronous posedge write with WB bypass;
  - scoreboard counters that cover variable-latency (cache-miss) writers;
  - killed writebacks for flushed instructions.

---
 rtl/regfile_scoreboard_pkg.sv | 18 +
 rtl/regfile_scoreboard_if.sv | 53 +++++
 rtl/regfile_scoreboard_operand_resolve.sv | 48 ++++
 rtl/regfile_scoreboard.sv | 132 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the ID-stage register file / scoreboard.
//   - default datapath, register-file and forwarding geometry
//   - forwarding index convention: index 0 is the youngest stage (EX),
//     higher indices are progressively older (MEM, ...)
//   - pend_t: per-register in-flight writer counter sized by MAX_PEND
package regfile_scoreboard_pkg;

   localparam int WORD_SIZE_DEF = 16;
   localparam int NUM_REGS_DEF  = 4;
   localparam int NUM_FWD_DEF   = 2;
   localparam int MAX_PEND_DEF  = 3;
   localparam int PEND_W_DEF    = $clog2(MAX_PEND_DEF + 1);

   localparam int FWD_YOUNGEST  = 0;

   typedef logic [PEND_W_DEF-1:0] pend_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus between the decode stage (master) and the register file / scoreboard
// (slave).
//   master drives: source addresses/usage, issue request and destination,
//                  forwarding stage taps, writeback port
//   slave drives:  resolved operands, stall, sticky underflow flag,
//                  stall cycle counter
interface regfile_scoreboard_if
   import regfile_scoreboard_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int NUM_REGS  = NUM_REGS_DEF,
   parameter int NUM_FWD   = NUM_FWD_DEF,
   parameter int RA_W      = $clog2(NUM_REGS)
) ();

   logic [RA_W-1:0]              rs_addr;
   logic [RA_W-1:0]              rt_addr;
   logic                         rs_used;
   logic                         rt_used;
   logic                         issue_valid;
   logic                         issue_dst_valid;
   logic [RA_W-1:0]              issue_dst;
   logic [NUM_FWD-1:0]           fwd_valid;
   logic [NUM_FWD-1:0]           fwd_ready;
   logic [NUM_FWD*RA_W-1:0]      fwd_addr;
   logic [NUM_FWD*WORD_SIZE-1:0] fwd_data;
   logic                         wb_valid;
   logic                         wb_kill;
   logic [RA_W-1:0]              wb_addr;
   logic [WORD_SIZE-1:0]         wb_data;
   logic [WORD_SIZE-1:0]         rs_data;
   logic [WORD_SIZE-1:0]         rt_data;
   logic                         stall;
   logic                         err_underflow;
   logic [WORD_SIZE-1:0]         stall_cycles;

   modport master (
      output rs_addr, rt_addr, rs_used, rt_used,
      output issue_valid, issue_dst_valid, issue_dst,
      output fwd_valid, fwd_ready, fwd_addr, fwd_data,
      output wb_valid, wb_kill, wb_addr, wb_data,
      input  rs_data, rt_data, stall, err_underflow, stall_cycles
   );

   modport slave (
      input  rs_addr, rt_addr, rs_used, rt_used,
      input  issue_valid, issue_dst_valid, issue_dst,
      input  fwd_valid, fwd_ready, fwd_addr, fwd_data,
      input  wb_valid, wb_kill, wb_addr, wb_data,
      output rs_data, rt_data, stall, err_underflow, stall_cycles
   );

endinterface

// File: rtl/regfile_scoreboard_operand_resolve.sv
// Priority operand mux for one source register.
//   addr        source register
//   fwd_*       forwarding stage taps, stage i at [i*W +: W], 0 = youngest
//   wb_bypass   writeback is live (valid and not killed)
//   wb_addr/data writeback target and value
//   pend_busy   scoreboard says an invisible writer is in flight
//   reg_data    architectural register contents
//   data        resolved operand
//   hazard      operand cannot be supplied this cycle
module regfile_scoreboard_operand_resolve
   import regfile_scoreboard_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int RA_W      = 2,
   parameter int NUM_FWD   = NUM_FWD_DEF
) (
   input  logic [RA_W-1:0]              addr,
   input  logic [NUM_FWD-1:0]           fwd_valid,
   input  logic [NUM_FWD-1:0]           fwd_ready,
   input  logic [NUM_FWD*RA_W-1:0]      fwd_addr,
   input  logic [NUM_FWD*WORD_SIZE-1:0] fwd_data,
   input  logic                         wb_bypass,
   input  logic [RA_W-1:0]              wb_addr,
   input  logic [WORD_SIZE-1:0]         wb_data,
   input  logic                         pend_busy,
   input  logic [WORD_SIZE-1:0]         reg_data,
   output logic [WORD_SIZE-1:0]         data,
   output logic                         hazard
);

   // Lowest priority first; each later match overrides, so the loop walks
   // from the oldest forwarding stage towards the youngest.
   always_comb begin
      data   = reg_data;
      hazard = pend_busy;
      if (wb_bypass && wb_addr == addr) begin
         data   = wb_data;
         hazard = 1'b0;
      end
      for (int i = NUM_FWD - 1; i >= FWD_YOUNGEST; i--) begin
         if (fwd_valid[i] && fwd_addr[i*RA_W +: RA_W] == addr) begin
            data   = fwd_data[i*WORD_SIZE +: WORD_SIZE];
            hazard = !fwd_ready[i];
         end
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// ID-stage register file with pending-write scoreboard and N-source bypass.
//   clk      clock, all state on posedge
//   Reset_N  synchronous active-low reset
//   bus      slave side of regfile_scoreboard_if (operand requests, issue,
//            forwarding taps, writeback; returns operands, stall, status)
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int NUM_REGS  = NUM_REGS_DEF,
   parameter int RA_W      = $clog2(NUM_REGS),
   parameter int NUM_FWD   = NUM_FWD_DEF,
   parameter int MAX_PEND  = MAX_PEND_DEF,
   parameter int PEND_W    = $clog2(MAX_PEND + 1)
) (
   input  logic               clk,
   input  logic               Reset_N,
   regfile_scoreboard_if.slave bus
);

   logic [WORD_SIZE-1:0] regs    [NUM_REGS];
   logic [PEND_W-1:0]    pending [NUM_REGS];
   logic                 err_q;
   logic [WORD_SIZE-1:0] stall_cnt;

   logic [WORD_SIZE-1:0] rs_res;
   logic [WORD_SIZE-1:0] rt_res;
   logic                 rs_haz;
   logic                 rt_haz;
   logic                 wb_live;
   logic                 waw_full;
   logic                 stall_raw;
   logic                 accept;
   logic                 underflow;
   logic [NUM_REGS-1:0]  pend_inc;
   logic [NUM_REGS-1:0]  pend_dec;

   assign wb_live = bus.wb_valid && !bus.wb_kill;

   regfile_scoreboard_operand_resolve #(
      .WORD_SIZE (WORD_SIZE),
      .RA_W      (RA_W),
      .NUM_FWD   (NUM_FWD)
   ) u_rs (
      .addr      (bus.rs_addr),
      .fwd_valid (bus.fwd_valid),
      .fwd_ready (bus.fwd_ready),
      .fwd_addr  (bus.fwd_addr),
      .fwd_data  (bus.fwd_data),
      .wb_bypass (wb_live),
      .wb_addr   (bus.wb_addr),
      .wb_data   (bus.wb_data),
      .pend_busy (pending[bus.rs_addr] != '0),
      .reg_data  (regs[bus.rs_addr]),
      .data      (rs_res),
      .hazard    (rs_haz)
   );

   regfile_scoreboard_operand_resolve #(
      .WORD_SIZE (WORD_SIZE),
      .RA_W      (RA_W),
      .NUM_FWD   (NUM_FWD)
   ) u_rt (
      .addr      (bus.rt_addr),
      .fwd_valid (bus.fwd_valid),
      .fwd_ready (bus.fwd_ready),
      .fwd_addr  (bus.fwd_addr),
      .fwd_data  (bus.fwd_data),
      .wb_bypass (wb_live),
      .wb_addr   (bus.wb_addr),
      .wb_data   (bus.wb_data),
      .pend_busy (pending[bus.rt_addr] != '0),
      .reg_data  (regs[bus.rt_addr]),
      .data      (rt_res),
      .hazard    (rt_haz)
   );

   // A full counter would wrap on another issue, so the destination must
   // drain first even though the data hazard logic may be clear.
   assign waw_full  = bus.issue_dst_valid && (pending[bus.issue_dst] == PEND_W'(MAX_PEND));
   assign stall_raw = bus.issue_valid &&
                      ((bus.rs_used && rs_haz) || (bus.rt_used && rt_haz) || waw_full);
   assign accept    = bus.issue_valid && !stall_raw;

   always_comb begin
      pend_inc = '0;
      pend_dec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         pend_inc[r] = accept && bus.issue_dst_valid && (bus.issue_dst == RA_W'(r));
         pend_dec[r] = bus.wb_valid && (bus.wb_addr == RA_W'(r));
      end
   end

   // A same-cycle issue to the retiring register cancels the decrement, so
   // that case is never an underflow.
   assign underflow = bus.wb_valid && (pending[bus.wb_addr] == '0) && !pend_inc[bus.wb_addr];

   always_ff @(posedge clk) begin
      if (!Reset_N) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r]    <= '0;
            pending[r] <= '0;
         end
         err_q     <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (wb_live) begin
            regs[bus.wb_addr] <= bus.wb_data;
         end
         for (int r = 0; r < NUM_REGS; r++) begin
            if (pend_inc[r] && !pend_dec[r]) begin
               pending[r] <= pending[r] + PEND_W'(1);
            end else if (pend_dec[r] && !pend_inc[r] && pending[r] != '0) begin
               pending[r] <= pending[r] - PEND_W'(1);
            end
         end
         if (underflow) begin
            err_q <= 1'b1;
         end
         if (stall_raw && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + WORD_SIZE'(1);
         end
      end
   end

   assign bus.rs_data       = Reset_N ? rs_res : '0;
   assign bus.rt_data       = Reset_N ? rt_res : '0;
   assign bus.stall         = Reset_N && stall_raw;
   assign bus.err_underflow = err_q;
   assign bus.stall_cycles  = stall_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   localparam int W   = 16;
   localparam int NR  = 4;
   localparam int RAW = 2;
   localparam int NF  = 2;
   localparam int MP  = 3;
   localparam int PW  = 2;

   logic clk = 1'b0;
   logic Reset_N;

   always #5 clk = ~clk;

   regfile_scoreboard_if #(.WORD_SIZE(W), .NUM_REGS(NR), .NUM_FWD(NF), .RA_W(RAW)) bus ();

   regfile_scoreboard #(
      .WORD_SIZE (W),
      .NUM_REGS  (NR),
      .RA_W      (RAW),
      .NUM_FWD   (NF),
      .MAX_PEND  (MP),
      .PEND_W    (PW)
   ) dut (
      .clk     (clk),
      .Reset_N (Reset_N),
      .bus     (bus)
   );

   // Reference model state
   int m_regs [NR];
   int m_pend [NR];
   bit m_err;
   int m_scyc;
   bit exp_stall;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.rs_addr         = '0;
      bus.rt_addr         = '0;
      bus.rs_used         = 1'b0;
      bus.rt_used         = 1'b0;
      bus.issue_valid     = 1'b0;
      bus.issue_dst_valid = 1'b0;
      bus.issue_dst       = '0;
      bus.fwd_valid       = '0;
      bus.fwd_ready       = '0;
      bus.fwd_addr        = '0;
      bus.fwd_data        = '0;
      bus.wb_valid        = 1'b0;
      bus.wb_kill         = 1'b0;
      bus.wb_addr         = '0;
      bus.wb_data         = '0;
   endtask

   // Operand lookup straight from the priority rules: youngest forwarding
   // match, then live writeback, then scoreboard, then the register value.
   function automatic void resolve(input int a, output int data, output bit haz);
      haz  = 1'b0;
      data = m_regs[a];
      for (int i = 0; i < NF; i++) begin
         if (bus.fwd_valid[i] && int'(bus.fwd_addr[i*RAW +: RAW]) == a) begin
            if (bus.fwd_ready[i]) data = int'(bus.fwd_data[i*W +: W]);
            else                  haz  = 1'b1;
            return;
         end
      end
      if (bus.wb_valid && !bus.wb_kill && int'(bus.wb_addr) == a) begin
         data = int'(bus.wb_data);
         return;
      end
      if (m_pend[a] != 0) haz = 1'b1;
   endfunction

   task automatic settle();
      int d_rs, d_rt;
      bit h_rs, h_rt;
      @(negedge clk);
      chk("err_underflow", bus.err_underflow, m_err);
      chk("stall_cycles", bus.stall_cycles, m_scyc);
      if (!Reset_N) begin
         exp_stall = 1'b0;
         chk("rs_data_rst", bus.rs_data, 0);
         chk("rt_data_rst", bus.rt_data, 0);
         chk("stall_rst", bus.stall, 0);
      end else begin
         resolve(int'(bus.rs_addr), d_rs, h_rs);
         resolve(int'(bus.rt_addr), d_rt, h_rt);
         if (!h_rs) chk("rs_data", bus.rs_data, d_rs);
         if (!h_rt) chk("rt_data", bus.rt_data, d_rt);
         exp_stall = bus.issue_valid &&
                     ((bus.rs_used && h_rs) || (bus.rt_used && h_rt) ||
                      (bus.issue_dst_valid && m_pend[bus.issue_dst] == MP));
         chk("stall", bus.stall, exp_stall);
      end
   endtask

   task automatic commit();
      int inc_r, dec_r;
      @(posedge clk);
      if (!Reset_N) begin
         for (int r = 0; r < NR; r++) begin
            m_regs[r] = 0;
            m_pend[r] = 0;
         end
         m_err  = 1'b0;
         m_scyc = 0;
      end else begin
         inc_r = (bus.issue_valid && !exp_stall && bus.issue_dst_valid) ? int'(bus.issue_dst) : -1;
         dec_r = bus.wb_valid ? int'(bus.wb_addr) : -1;
         if (exp_stall && m_scyc < 65535) m_scyc++;
         if (bus.wb_valid && !bus.wb_kill) m_regs[dec_r] = int'(bus.wb_data);
         if (dec_r >= 0 && dec_r != inc_r) begin
            if (m_pend[dec_r] == 0) m_err = 1'b1;
            else                    m_pend[dec_r]--;
         end
         if (inc_r >= 0 && inc_r != dec_r) m_pend[inc_r]++;
      end
      #1;
   endtask

   task automatic step();
      settle();
      commit();
   endtask

   task automatic issue_dst(input int r);
      idle();
      bus.issue_valid     = 1'b1;
      bus.issue_dst_valid = 1'b1;
      bus.issue_dst       = RAW'(r);
   endtask

   initial begin
      idle();
      Reset_N = 1'b0;
      step();
      step();
      Reset_N = 1'b1;

      // Reset contents
      for (int r = 0; r < NR; r++) begin
         idle();
         bus.rs_addr = RAW'(r);
         bus.rt_addr = RAW'(r);
         settle();
         chk("tp_reset_rs", bus.rs_data, 0);
         chk("tp_reset_rt", bus.rt_data, 0);
         chk("tp_reset_stall", bus.stall, 0);
         commit();
      end

      // EX forwarding, youngest wins
      issue_dst(1);
      step();
      idle();
      bus.issue_valid = 1'b1;
      bus.rs_used     = 1'b1;
      bus.rs_addr     = 2'd1;
      bus.fwd_valid   = 2'b01;
      bus.fwd_ready   = 2'b01;
      bus.fwd_addr    = 4'b0001;
      bus.fwd_data    = {16'h0000, 16'h1234};
      settle();
      chk("tp_fwd_ex", bus.rs_data, 32'h1234);
      chk("tp_fwd_ex_stall", bus.stall, 0);
      commit();
      bus.fwd_valid = 2'b11;
      bus.fwd_ready = 2'b11;
      bus.fwd_addr  = 4'b0101;
      bus.fwd_data  = {16'h1111, 16'h5678};
      settle();
      chk("tp_fwd_youngest", bus.rs_data, 32'h5678);
      commit();

      // Load-use
      idle();
      bus.issue_valid = 1'b1;
      bus.rt_used     = 1'b1;
      bus.rt_addr     = 2'd2;
      bus.fwd_valid   = 2'b01;
      bus.fwd_ready   = 2'b00;
      bus.fwd_addr    = 4'b0010;
      settle();
      chk("tp_loaduse_stall", bus.stall, 1);
      commit();
      bus.fwd_ready = 2'b01;
      bus.fwd_data  = {16'h0000, 16'hBEEF};
      settle();
      chk("tp_loaduse_release", bus.stall, 0);
      chk("tp_loaduse_data", bus.rt_data, 32'hBEEF);
      chk("tp_loaduse_count", bus.stall_cycles, 1);
      commit();

      // Cache-miss hold on R3, released by writeback bypass
      issue_dst(3);
      step();
      idle();
      bus.issue_valid = 1'b1;
      bus.rs_used     = 1'b1;
      bus.rs_addr     = 2'd3;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("tp_miss_hold", bus.stall, 1);
         commit();
      end
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 2'd3;
      bus.wb_data  = 16'h00AA;
      settle();
      chk("tp_miss_bypass", bus.rs_data, 32'h00AA);
      chk("tp_miss_release", bus.stall, 0);
      commit();
      bus.wb_valid = 1'b0;
      settle();
      chk("tp_miss_after", bus.stall, 0);
      chk("tp_miss_after_data", bus.rs_data, 32'h00AA);
      commit();

      // Killed writeback
      issue_dst(0);
      step();
      idle();
      bus.issue_valid = 1'b1;
      bus.rs_used     = 1'b1;
      bus.rs_addr     = 2'd0;
      bus.wb_valid    = 1'b1;
      bus.wb_kill     = 1'b1;
      bus.wb_addr     = 2'd0;
      bus.wb_data     = 16'hFFFF;
      settle();
      chk("tp_kill_no_bypass", bus.stall, 1);
      commit();
      idle();
      bus.issue_valid = 1'b1;
      bus.rs_used     = 1'b1;
      bus.rs_addr     = 2'd0;
      settle();
      chk("tp_kill_reg", bus.rs_data, 0);
      chk("tp_kill_pend", bus.stall, 0);
      chk("tp_kill_no_err", bus.err_underflow, 0);
      commit();
      idle();
      bus.wb_valid = 1'b1;
      bus.wb_kill  = 1'b1;
      bus.wb_addr  = 2'd0;
      bus.wb_data  = 16'hFFFF;
      step();
      idle();
      settle();
      chk("tp_underflow", bus.err_underflow, 1);
      commit();

      // WAW saturation on R1
      idle();
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 2'd1;
      bus.wb_data  = 16'h0101;
      step();
      for (int k = 0; k < MP; k++) begin
         issue_dst(1);
         settle();
         chk("tp_sat_fill", bus.stall, 0);
         commit();
      end
      issue_dst(1);
      settle();
      chk("tp_sat_stall", bus.stall, 1);
      commit();
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 2'd1;
      bus.wb_data  = 16'h0002;
      settle();
      chk("tp_sat_stall_wb", bus.stall, 1);
      commit();
      issue_dst(1);
      settle();
      chk("tp_sat_at_two", bus.stall, 0);
      commit();
      settle();
      chk("tp_sat_full_again", bus.stall, 1);
      commit();

      // Mid-stream reset
      Reset_N      = 1'b0;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 2'd1;
      settle();
      chk("tp_rst_forced_stall", bus.stall, 0);
      commit();
      Reset_N = 1'b1;
      issue_dst(1);
      bus.rs_used = 1'b1;
      bus.rs_addr = 2'd3;
      settle();
      chk("tp_rst_pend_clear", bus.stall, 0);
      chk("tp_rst_regs_clear", bus.rs_data, 0);
      chk("tp_rst_err_clear", bus.err_underflow, 0);
      chk("tp_rst_scyc_clear", bus.stall_cycles, 0);
      commit();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         Reset_N             = ($urandom_range(0, 199) != 0);
         bus.rs_addr         = RAW'($urandom_range(0, NR - 1));
         bus.rt_addr         = RAW'($urandom_range(0, NR - 1));
         bus.rs_used         = 1'($urandom);
         bus.rt_used         = 1'($urandom);
         bus.issue_valid     = ($urandom_range(0, 3) != 0);
         bus.issue_dst_valid = 1'($urandom);
         bus.issue_dst       = RAW'($urandom_range(0, NR - 1));
         bus.fwd_valid       = NF'($urandom);
         bus.fwd_ready       = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         bus.fwd_addr        = (NF*RAW)'($urandom);
         bus.fwd_data        = (NF*W)'($urandom);
         bus.wb_valid        = ($urandom_range(0, 2) == 0);
         bus.wb_kill         = ($urandom_range(0, 5) == 0);
         bus.wb_addr         = RAW'($urandom_range(0, NR - 1));
         bus.wb_data         = W'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
